// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: sequences FETCH/LATCH/DECODE/MEM/COMMIT
// and decodes the latched instruction into dataflow selects and write strobes.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rs_i,
   input  logic [31:0] insn,
   input  logic        EQ,
   input  logic        LS,
   input  logic        LU,
   input  logic        mem_ready,
   output logic        mem_re,
   output logic        mem_we,
   output logic        insn_clk,
   output logic        pc_clk,
   output logic        rd_clk,
   output logic        pc_next_sel,
   output logic        pc_alu_sel,
   output logic        alu_sel_a,
   output logic        alu_sel_b,
   output logic        addr_sel,
   output logic        sub_sra,
   output logic [1:0]  rd_sel,
   output logic [2:0]  func,
   output logic [2:0]  mem_size,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [31:0] imm,
   output logic        halted,
   output logic        fault
);

   localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_MISC   = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam int unsigned B_FETCH  = 0;
   localparam int unsigned B_LATCH  = 1;
   localparam int unsigned B_MEM    = 3;
   localparam int unsigned B_COMMIT = 4;
   localparam int unsigned B_HALT   = 5;

   typedef enum logic [5:0] {
      S_FETCH  = 6'b000001,
      S_LATCH  = 6'b000010,
      S_DECODE = 6'b000100,
      S_MEM    = 6'b001000,
      S_COMMIT = 6'b010000,
      S_HALT   = 6'b100000
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] wait_cnt;
   logic             waiting, fault_set;
   logic             is_load, is_store, is_sys, illegal, writes_rd, taken;
   logic [2:0]       funct3;
   logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j;

   assign funct3   = insn[14:12];
   assign mem_size = funct3;
   assign rs1      = insn[19:15];
   assign rs2      = insn[24:20];
   assign rd       = insn[11:7];
   assign halted   = state[B_HALT];

   assign imm_i = {{20{insn[31]}}, insn[31:20]};
   assign imm_s = {{20{insn[31]}}, insn[31:25], insn[11:7]};
   assign imm_b = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
   assign imm_u = {insn[31:12], 12'b0};
   assign imm_j = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};

   // Instruction decode: selects are a pure function of the latched insn and flags.
   always_comb begin
      pc_next_sel = 1'b0;
      pc_alu_sel  = 1'b0;
      alu_sel_a   = 1'b0;
      alu_sel_b   = 1'b0;
      func        = funct3;
      sub_sra     = 1'b0;
      rd_sel      = 2'd2;
      imm         = imm_i;
      writes_rd   = 1'b0;
      is_load     = 1'b0;
      is_store    = 1'b0;
      is_sys      = 1'b0;
      illegal     = 1'b0;
      taken       = 1'b0;
      case (insn[6:0])
         OPC_OP: begin
            sub_sra   = insn[30];
            writes_rd = 1'b1;
         end
         OPC_OPIMM: begin
            alu_sel_b = 1'b1;
            sub_sra   = (funct3 == 3'b101) & insn[30];
            writes_rd = 1'b1;
         end
         OPC_LUI: begin
            rd_sel    = 2'd1;
            imm       = imm_u;
            writes_rd = 1'b1;
         end
         OPC_AUIPC: begin
            alu_sel_a = 1'b1;
            alu_sel_b = 1'b1;
            func      = 3'b000;
            imm       = imm_u;
            writes_rd = 1'b1;
         end
         OPC_JAL: begin
            alu_sel_a   = 1'b1;
            alu_sel_b   = 1'b1;
            func        = 3'b000;
            pc_next_sel = 1'b1;
            rd_sel      = 2'd3;
            imm         = imm_j;
            writes_rd   = 1'b1;
         end
         OPC_JALR: begin
            alu_sel_b   = 1'b1;
            func        = 3'b000;
            pc_next_sel = 1'b1;
            rd_sel      = 2'd3;
            writes_rd   = 1'b1;
         end
         OPC_BRANCH: begin
            imm = imm_b;
            case (funct3)
               3'b000:  taken = EQ;
               3'b001:  taken = ~EQ;
               3'b100:  taken = LS;
               3'b101:  taken = ~LS;
               3'b110:  taken = LU;
               3'b111:  taken = ~LU;
               default: illegal = 1'b1;
            endcase
            pc_alu_sel = taken;
         end
         OPC_LOAD: begin
            alu_sel_b = 1'b1;
            func      = 3'b000;
            rd_sel    = 2'd0;
            is_load   = 1'b1;
            writes_rd = 1'b1;
         end
         OPC_STORE: begin
            alu_sel_b = 1'b1;
            func      = 3'b000;
            imm       = imm_s;
            is_store  = 1'b1;
         end
         OPC_MISC: begin
         end
         OPC_SYSTEM: begin
            if (insn == 32'h0000_0073 || insn == 32'h0010_0073) is_sys = 1'b1;
            else illegal = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   // Next state, timeout detection and state-bit-decoded strobes.
   always_comb begin
      state_next = state;
      waiting    = 1'b0;
      fault_set  = 1'b0;
      addr_sel   = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      insn_clk   = 1'b0;
      pc_clk     = 1'b0;
      rd_clk     = 1'b0;
      case (state)
         S_FETCH:  if (mem_ready) state_next = S_LATCH; else waiting = 1'b1;
         S_LATCH:  state_next = S_DECODE;
         S_DECODE: begin
            if (illegal) begin
               state_next = S_HALT;
               fault_set  = 1'b1;
            end else if (is_sys)            state_next = S_HALT;
            else if (is_load || is_store)   state_next = S_MEM;
            else                            state_next = S_COMMIT;
         end
         S_MEM:    if (mem_ready) state_next = S_COMMIT; else waiting = 1'b1;
         S_COMMIT: state_next = S_FETCH;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_FETCH;
      endcase
      if (waiting && MEM_TIMEOUT != 0 && (32'(wait_cnt) + 32'd1 >= MEM_TIMEOUT)) begin
         state_next = S_HALT;
         fault_set  = 1'b1;
      end
      addr_sel = state[B_MEM];
      if (!rs_i) begin
         mem_re   = state[B_FETCH] | (state[B_MEM] & is_load);
         mem_we   = state[B_MEM] & is_store;
         insn_clk = state[B_LATCH];
         pc_clk   = state[B_COMMIT];
         rd_clk   = state[B_COMMIT] & writes_rd & (rd != 5'd0);
      end
   end

   // State register, wait counter and sticky fault flag.
   always_ff @(posedge clk) begin
      if (rs_i) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         fault    <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next != state) wait_cnt <= '0;
         else if (waiting)        wait_cnt <= wait_cnt + 1'b1;
         if (fault_set) fault <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl with an instruction-level model.
module tb_multicycle_ctrl;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rs_i, EQ, LS, LU, mem_ready;
   logic [31:0] insn;
   logic        mem_re, mem_we, insn_clk, pc_clk, rd_clk;
   logic        pc_next_sel, pc_alu_sel, alu_sel_a, alu_sel_b, addr_sel, sub_sra;
   logic [1:0]  rd_sel;
   logic [2:0]  func, mem_size;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic        halted, fault;

   multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rs_i(rs_i), .insn(insn), .EQ(EQ), .LS(LS), .LU(LU),
      .mem_ready(mem_ready), .mem_re(mem_re), .mem_we(mem_we),
      .insn_clk(insn_clk), .pc_clk(pc_clk), .rd_clk(rd_clk),
      .pc_next_sel(pc_next_sel), .pc_alu_sel(pc_alu_sel), .alu_sel_a(alu_sel_a),
      .alu_sel_b(alu_sel_b), .addr_sel(addr_sel), .sub_sra(sub_sra),
      .rd_sel(rd_sel), .func(func), .mem_size(mem_size),
      .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef enum int {K_OP, K_OPIMM, K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR,
                     K_LOAD, K_STORE, K_FENCE, K_ECALL, K_EBREAK, K_ILL} kind_t;

   typedef struct {
      kind_t      k;
      logic [4:0] rd, rs1, rs2;
      logic [2:0] f3;
      logic       alt;
      int         imm;
   } ins_t;

   typedef struct {
      logic mem_re, mem_we, insn_clk, pc_clk, rd_clk;
      logic c_stat, halted, fault;
      logic c_addr, addr_sel;
      logic c_pc, pc_next_sel, pc_alu_sel;
      logic c_a, alu_sel_a, c_b, alu_sel_b;
      logic c_func; logic [2:0] func;
      logic c_sub, sub_sra;
      logic c_rdsel; logic [1:0] rd_sel;
      logic c_size; logic [2:0] mem_size;
      logic c_imm; logic [31:0] imm;
      logic c_rs1, c_rs2, c_rd; logic [4:0] rs1, rs2, rd;
   } exp_t;

   exp_t e;
   logic chk_en = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   ncyc = 0;
   int   seen_pc = 0;
   int   seen_ic = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t idle();
      exp_t x;
      x = '{default: '0};
      x.c_stat = 1'b1;
      return x;
   endfunction

   // Assemble an instruction word from its fields.
   function automatic logic [31:0] enc(input ins_t i);
      logic [31:0] v;
      logic [31:0] w;
      v = 32'(i.imm);
      w = '0;
      case (i.k)
         K_OP:     w = {(i.alt ? 7'b0100000 : 7'b0000000), i.rs2, i.rs1, i.f3, i.rd, 7'b0110011};
         K_OPIMM:  w = {v[11:0], i.rs1, i.f3, i.rd, 7'b0010011};
         K_LUI:    w = {v[31:12], i.rd, 7'b0110111};
         K_AUIPC:  w = {v[31:12], i.rd, 7'b0010111};
         K_JAL:    w = {v[20], v[10:1], v[11], v[19:12], i.rd, 7'b1101111};
         K_JALR:   w = {v[11:0], i.rs1, 3'b000, i.rd, 7'b1100111};
         K_BR:     w = {v[12], v[10:5], i.rs2, i.rs1, i.f3, v[4:1], v[11], 7'b1100011};
         K_LOAD:   w = {v[11:0], i.rs1, i.f3, i.rd, 7'b0000011};
         K_STORE:  w = {v[11:5], i.rs2, i.rs1, i.f3, v[4:0], 7'b0100011};
         K_FENCE:  w = 32'h0ff0000f;
         K_ECALL:  w = 32'h00000073;
         K_EBREAK: w = 32'h00100073;
         default:  w = i.alt ? {7'b0, i.rs2, i.rs1, i.f3, 5'b0, 7'b1100011}
                             : {v[24:0], 7'b1111111};
      endcase
      return w;
   endfunction

   function automatic logic writes(input kind_t k);
      return k == K_OP || k == K_OPIMM || k == K_LUI || k == K_AUIPC ||
             k == K_JAL || k == K_JALR || k == K_LOAD;
   endfunction

   function automatic logic halts(input kind_t k);
      return k == K_ECALL || k == K_EBREAK || k == K_ILL;
   endfunction

   // Required selects while an instruction is in DECODE/MEM/COMMIT.
   function automatic exp_t sel_model(input ins_t i, input logic eq, input logic ls, input logic lu);
      exp_t x;
      logic tk;
      x = idle();
      if (halts(i.k)) return x;
      case (i.f3)
         3'd0:    tk = eq;
         3'd1:    tk = !eq;
         3'd4:    tk = ls;
         3'd5:    tk = !ls;
         3'd6:    tk = lu;
         default: tk = !lu;
      endcase
      x.c_pc = 1'b1;
      x.pc_next_sel = (i.k == K_JAL || i.k == K_JALR);
      x.pc_alu_sel  = (i.k == K_BR) && tk;
      x.rs1 = i.rs1; x.rs2 = i.rs2; x.rd = i.rd;
      x.imm = 32'(i.imm);
      x.func = i.f3;
      x.mem_size = i.f3;
      case (i.k)
         K_OP: begin
            x.c_a = 1; x.c_b = 1; x.c_func = 1; x.c_sub = 1; x.sub_sra = i.alt;
            x.c_rdsel = 1; x.rd_sel = 2'd2; x.c_rs1 = 1; x.c_rs2 = 1; x.c_rd = 1;
         end
         K_OPIMM: begin
            x.c_b = 1; x.alu_sel_b = 1; x.c_func = 1;
            x.c_sub = 1; x.sub_sra = (i.f3 == 3'd5) && i.alt;
            x.c_rdsel = 1; x.rd_sel = 2'd2; x.c_imm = 1; x.c_rs1 = 1; x.c_rd = 1;
         end
         K_LUI: begin
            x.c_rdsel = 1; x.rd_sel = 2'd1; x.c_imm = 1; x.c_rd = 1;
         end
         K_AUIPC, K_JAL: begin
            x.c_a = 1; x.alu_sel_a = 1; x.c_b = 1; x.alu_sel_b = 1;
            x.c_func = 1; x.func = 3'd0; x.c_imm = 1; x.c_rd = 1;
            x.c_rdsel = 1; x.rd_sel = (i.k == K_JAL) ? 2'd3 : 2'd2;
         end
         K_JALR: begin
            x.c_a = 1; x.c_b = 1; x.alu_sel_b = 1; x.c_rdsel = 1; x.rd_sel = 2'd3;
            x.c_imm = 1; x.c_rs1 = 1; x.c_rd = 1;
         end
         K_BR: begin
            x.c_a = 1; x.c_b = 1; x.c_imm = 1; x.c_rs1 = 1; x.c_rs2 = 1;
         end
         K_LOAD: begin
            x.c_rdsel = 1; x.rd_sel = 2'd0; x.c_size = 1; x.c_imm = 1; x.c_rs1 = 1; x.c_rd = 1;
         end
         K_STORE: begin
            x.c_size = 1; x.c_imm = 1; x.c_rs1 = 1; x.c_rs2 = 1;
         end
         default: ;
      endcase
      return x;
   endfunction

   function automatic int simm12();
      return int'($urandom_range(0, 4095)) - 2048;
   endfunction

   function automatic ins_t rand_ins();
      ins_t i;
      int   r;
      i.k = kind_t'($urandom_range(0, 12));
      i.rd = 5'($urandom); i.rs1 = 5'($urandom); i.rs2 = 5'($urandom);
      i.f3 = 3'($urandom); i.alt = 1'b0; i.imm = simm12();
      case (i.k)
         K_OP: if (i.f3 == 3'd0 || i.f3 == 3'd5) i.alt = 1'($urandom);
         K_OPIMM: begin
            if (i.f3 == 3'd1) i.imm = int'($urandom_range(0, 31));
            if (i.f3 == 3'd5) begin
               i.alt = 1'($urandom);
               i.imm = (i.alt ? 1024 : 0) + int'($urandom_range(0, 31));
            end
         end
         K_LUI, K_AUIPC: i.imm = int'($urandom & 32'hFFFF_F000);
         K_JAL: i.imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
         K_BR: begin
            r = int'($urandom_range(0, 5));
            i.f3 = (r < 2) ? 3'(r) : 3'(r + 2);
            i.imm = simm12() * 2;
         end
         K_LOAD: begin
            r = int'($urandom_range(0, 4));
            i.f3 = (r < 3) ? 3'(r) : 3'(r + 1);
         end
         K_STORE: i.f3 = 3'($urandom_range(0, 2));
         K_ILL: begin
            i.alt = 1'($urandom);
            if (i.alt) i.f3 = 3'($urandom_range(2, 3));
         end
         default: ;
      endcase
      return i;
   endfunction

   task automatic step();
      ncyc++;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rs_i = 1'b1;
      mem_ready = 1'($urandom);
      e = idle();
      e.c_stat = 1'b0;
      step();
      rs_i = 1'b0;
      mem_ready = 1'b0;
   endtask

   task automatic halt_seq(input logic f);
      for (int c = 0; c < 3; c++) begin
         mem_ready = 1'($urandom);
         e = idle();
         e.halted = 1'b1;
         e.fault = f;
         step();
      end
      do_reset();
   endtask

   // Drive one instruction through the controller; fl<0 picks random flags.
   task automatic run_insn(input ins_t i, input int wf, input int wm, input int abort_mem, input int fl);
      exp_t d;
      logic eq, ls, lu;
      if (fl < 0) begin
         eq = 1'($urandom); ls = 1'($urandom); lu = 1'($urandom);
      end else begin
         eq = fl[0]; ls = fl[1]; lu = fl[2];
      end
      EQ = eq; LS = ls; LU = lu;
      ncyc = 0; seen_pc = 0; seen_ic = 0;
      for (int c = 0; c <= wf; c++) begin
         if (c == int'(TO)) begin
            halt_seq(1'b1);
            return;
         end
         mem_ready = (c == wf);
         e = idle(); e.mem_re = 1'b1; e.c_addr = 1'b1;
         step();
      end
      mem_ready = 1'b0;
      e = idle(); e.insn_clk = 1'b1; e.c_addr = 1'b1;
      step();
      insn = enc(i);
      d = sel_model(i, eq, ls, lu);
      e = d;
      step();
      if (halts(i.k)) begin
         halt_seq(i.k == K_ILL);
         return;
      end
      if (i.k == K_LOAD || i.k == K_STORE) begin
         for (int c = 0; c <= wm; c++) begin
            if (c == int'(TO)) begin
               halt_seq(1'b1);
               return;
            end
            mem_ready = (c == wm);
            if (c == abort_mem) begin
               rs_i = 1'b1;
               e = idle();
               step();
               rs_i = 1'b0;
               mem_ready = 1'b0;
               return;
            end
            e = d;
            e.mem_re = (i.k == K_LOAD); e.mem_we = (i.k == K_STORE);
            e.c_addr = 1; e.addr_sel = 1; e.c_a = 1; e.alu_sel_a = 0;
            e.c_b = 1; e.alu_sel_b = 1; e.c_func = 1; e.func = 3'd0; e.c_sub = 1; e.sub_sra = 0;
            step();
         end
      end
      mem_ready = 1'b0;
      e = d;
      e.pc_clk = 1'b1;
      e.rd_clk = writes(i.k) && (i.rd != 5'd0);
      step();
   endtask

   // Single compare process: every active cycle is checked against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("mem_re", 32'(mem_re), 32'(e.mem_re));
         chk("mem_we", 32'(mem_we), 32'(e.mem_we));
         chk("insn_clk", 32'(insn_clk), 32'(e.insn_clk));
         chk("pc_clk", 32'(pc_clk), 32'(e.pc_clk));
         chk("rd_clk", 32'(rd_clk), 32'(e.rd_clk));
         if (e.c_stat) begin
            chk("halted", 32'(halted), 32'(e.halted));
            chk("fault", 32'(fault), 32'(e.fault));
         end
         if (e.c_addr) chk("addr_sel", 32'(addr_sel), 32'(e.addr_sel));
         if (e.c_pc) begin
            chk("pc_next_sel", 32'(pc_next_sel), 32'(e.pc_next_sel));
            chk("pc_alu_sel", 32'(pc_alu_sel), 32'(e.pc_alu_sel));
         end
         if (e.c_a)     chk("alu_sel_a", 32'(alu_sel_a), 32'(e.alu_sel_a));
         if (e.c_b)     chk("alu_sel_b", 32'(alu_sel_b), 32'(e.alu_sel_b));
         if (e.c_func)  chk("func", 32'(func), 32'(e.func));
         if (e.c_sub)   chk("sub_sra", 32'(sub_sra), 32'(e.sub_sra));
         if (e.c_rdsel) chk("rd_sel", 32'(rd_sel), 32'(e.rd_sel));
         if (e.c_size)  chk("mem_size", 32'(mem_size), 32'(e.mem_size));
         if (e.c_imm)   chk("imm", imm, e.imm);
         if (e.c_rs1)   chk("rs1", 32'(rs1), 32'(e.rs1));
         if (e.c_rs2)   chk("rs2", 32'(rs2), 32'(e.rs2));
         if (e.c_rd)    chk("rd", 32'(rd), 32'(e.rd));
         if (pc_clk)   seen_pc = ncyc;
         if (insn_clk) seen_ic = ncyc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ins_t i;
      int   wf, wm, ab;
      rs_i = 1'b1; insn = '0; EQ = 0; LS = 0; LU = 0; mem_ready = 1'b0;
      e = idle();
      e.c_stat = 1'b0;
      @(posedge clk);
      #1;
      // Second reset cycle: strobes forced low, status already cleared.
      e = idle();
      step();
      rs_i = 1'b0;

      // ADDI x1,x0,5
      i = '{k: K_OPIMM, rd: 5'd1, rs1: 5'd0, rs2: 5'd5, f3: 3'd0, alt: 1'b0, imm: 5};
      chk("enc_addi", enc(i), 32'h00500093);
      run_insn(i, 0, 0, -1, 0);
      chk("addi_insn_clk_cycle", seen_ic, 2);
      chk("addi_commit_cycle", seen_pc, 4);

      // BEQ x0,x0,+8 taken then not taken
      i = '{k: K_BR, rd: 5'd8, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, alt: 1'b0, imm: 8};
      chk("enc_beq", enc(i), 32'h00000463);
      run_insn(i, 0, 0, -1, 1);
      run_insn(i, 0, 0, -1, 0);

      // JALR x1,0(x1)
      i = '{k: K_JALR, rd: 5'd1, rs1: 5'd1, rs2: 5'd0, f3: 3'd0, alt: 1'b0, imm: 0};
      chk("enc_jalr", enc(i), 32'h000080e7);
      run_insn(i, 0, 0, -1, 0);
      chk("jalr_commit_cycle", seen_pc, 4);

      // LW x2,4(x1) with three memory wait cycles
      i = '{k: K_LOAD, rd: 5'd2, rs1: 5'd1, rs2: 5'd4, f3: 3'd2, alt: 1'b0, imm: 4};
      chk("enc_lw", enc(i), 32'h0040a103);
      run_insn(i, 0, 3, -1, 0);
      chk("lw_commit_cycle", seen_pc, 8);

      // ADD x0,x1,x2: no register write
      i = '{k: K_OP, rd: 5'd0, rs1: 5'd1, rs2: 5'd2, f3: 3'd0, alt: 1'b0, imm: 0};
      chk("enc_add", enc(i), 32'h00208033);
      run_insn(i, 0, 0, -1, 0);

      // Opcode 0x7F, ECALL, EBREAK
      i = '{k: K_ILL, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, alt: 1'b0, imm: 0};
      run_insn(i, 0, 0, -1, 0);
      i.k = K_ECALL;
      run_insn(i, 0, 0, -1, 0);
      i.k = K_EBREAK;
      run_insn(i, 1, 0, -1, 0);

      // mem_ready stuck low in FETCH, then in MEM
      i = '{k: K_OPIMM, rd: 5'd1, rs1: 5'd0, rs2: 5'd5, f3: 3'd0, alt: 1'b0, imm: 5};
      run_insn(i, int'(TO), 0, -1, 0);
      i = '{k: K_LOAD, rd: 5'd3, rs1: 5'd1, rs2: 5'd0, f3: 3'd0, alt: 1'b0, imm: -4};
      run_insn(i, int'(TO) - 1, int'(TO), -1, 0);

      // Reset pulsed during a store MEM wait, then resume
      i = '{k: K_STORE, rd: 5'd0, rs1: 5'd2, rs2: 5'd7, f3: 3'd2, alt: 1'b0, imm: -12};
      run_insn(i, 0, 5, 2, 0);
      i = '{k: K_LUI, rd: 5'd9, rs1: 5'd0, rs2: 5'd0, f3: 3'd0, alt: 1'b0, imm: 32'h12345000};
      run_insn(i, 0, 0, -1, 0);

      // Randomized instruction stream
      for (int n = 0; n < 400; n++) begin
         i  = rand_ins();
         wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
         wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
         ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, wm)) : -1;
         run_insn(i, wf, wm, ab, -1);
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control unit for the RV32I dataflow.
- Decodes the latched instruction and sequences FETCH, DECODE, optional MEM, and COMMIT.
- Drives all dataflow selects, the immediate, and the three register write strobes (insn_clk, pc_clk, rd_clk), plus a simple ready-handshake to memory.
- Halts on illegal instructions, ECALL/EBREAK, or memory timeout.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for mem_ready in any wait state; 0 disables the timeout.

Ports:
- clk  in  1  single system clock
- rs_i  in  1  reset, synchronous, active-high
- insn  in  32  instruction register output from the dataflow
- EQ, LS, LU  in  1 each  ALU compare flags (A==B, signed A<B, unsigned A<B)
- mem_ready  in  1  memory access complete; data_o held valid until the next mem_re/mem_we
- mem_re, mem_we  out  1 each  memory read / write request
- insn_clk, pc_clk, rd_clk  out  1 each  one-cycle write strobes
- pc_next_sel, pc_alu_sel, alu_sel_a, alu_sel_b, addr_sel, sub_sra  out  1 each  datapath selects
- rd_sel  out  2  0=mem_extend, 1=imm, 2=alu, 3=pc_inc
- func, mem_size  out  3 each  ALU function; memory access size (= funct3)
- rs1, rs2, rd  out  5 each  register specifiers (insn[19:15], [24:20], [11:7])
- imm  out  32  sign-extended immediate (I/S/B/U/J by opcode)
- halted  out  1  controller stopped
- fault  out  1  stop caused by timeout or illegal opcode (0 for ECALL/EBREAK)

Behaviour:
- State register is one-hot: FETCH, LATCH, DECODE, MEM, COMMIT, HALT.
- Strobes and mem_re/mem_we decode directly from single state bits, so they are glitch-free.
- While rs_i=1, strobes and mem_re/mem_we are forced 0 combinationally.
- Reset: next state FETCH, timeout counter 0, halted=0, fault=0.
- FETCH: addr_sel=0, mem_re=1. mem_ready goes to LATCH.
- LATCH: insn_clk=1, addr_sel=0. Goes to DECODE.
- DECODE: selects are valid from insn.
  - Load/store goes to MEM.
  - Illegal opcode goes to HALT with fault=1.
  - ECALL/EBREAK goes to HALT with fault=0.
  - Everything else goes to COMMIT.
- MEM: addr_sel=1, alu_sel_a=0, alu_sel_b=1, func=000, sub_sra=0.
  - mem_re for loads, mem_we for stores; request held until mem_ready, then COMMIT.
- COMMIT: pc_clk=1. rd_clk=1 only if the instruction writes rd and rd!=0. Then FETCH.
- Selects stay constant from DECODE through COMMIT, so every strobe edge sees inputs that were stable for at least one prior cycle.
- Default pc path is pc_next_sel=0, pc_alu_sel=0 (pc+4).
- Per-opcode selects:
  - OP: alu_sel_a=0, alu_sel_b=0, func=funct3, sub_sra=insn[30], rd_sel=2.
  - OP-IMM: alu_sel_b=1, sub_sra=insn[30] only when funct3=101, otherwise 0.
  - LUI: rd_sel=1.
  - AUIPC: alu_sel_a=1, alu_sel_b=1, func=000, rd_sel=2.
  - JAL: alu_sel_a=1, alu_sel_b=1, func=000, pc_next_sel=1, rd_sel=3. rd receives old pc+4 and pc receives pc+imm on the same edge.
  - JALR: alu_sel_a=0, alu_sel_b=1, pc_next_sel=1, rd_sel=3. Correct when rd==rs1 because both sample old values. Target bit0 is not cleared.
  - BRANCH: alu_sel_a=0, alu_sel_b=0. pc_alu_sel=1 when taken.
    - Taken condition: BEQ EQ, BNE !EQ, BLT LS, BGE !LS, BLTU LU, BGEU !LU.
    - funct3 010/011 is illegal.
  - LOAD: rd_sel=0, mem_size=funct3.
  - STORE: no rd write, mem_size=funct3.
  - MISC-MEM (FENCE): NOP with pc+4 only.
- Latency with zero wait states:
  - ALU/branch/jump: 4 cycles (FETCH, LATCH, DECODE, COMMIT).
  - Load/store: 5 cycles.
  - Each extra wait cycle adds 1.
- Timeout: the counter counts consecutive cycles in FETCH or MEM with mem_ready=0.
  - Reaching MEM_TIMEOUT goes to HALT with fault=1.
  - Counter clears on state change.
- HALT: all strobes and mem enables 0, halted=1. Only rs_i leaves it.
- Reset mid-MEM with mem_we=1: mem_we drops in the same cycle. No pc_clk or rd_clk strobe from the aborted instruction.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready immediate → insn_clk in cycle 2; rd_clk and pc_clk together in cycle 4; rd_sel=2, alu_sel_b=1, imm=5.
- BEQ x0,x0,+8 (0x00000463) with EQ=1 → pc_alu_sel=1, imm=8, rd_clk=0. Same with EQ=0 → pc_alu_sel=0.
- JALR x1,0(x1) (0x000080e7) → pc_next_sel=1, rd_sel=3, pc_clk and rd_clk in the same cycle.
- LW x2,4(x1) with mem_ready delayed 3 cycles in MEM → mem_re held 4 cycles with addr_sel=1; COMMIT rd_sel=0, mem_size=010; total 8 cycles.
- ADD x0,x1,x2 → pc_clk=1, rd_clk=0. Opcode 0x7F → HALT, fault=1. ECALL → halted=1, fault=0.
- mem_ready stuck low in FETCH with MEM_TIMEOUT=16 → halted=1, fault=1 after 16 cycles. rs_i pulsed during a store MEM → mem_we=0 in the same cycle, restart in FETCH.
